// File: rtl/calc_pkg.sv
// calc_pkg
// Shared definitions for the RPN calculator engine and its stack.
//   - OP_* : 3-bit command opcodes carried on cmd_op_i
//   - state_e : engine FSM state encoding
//   - clog2 : elaboration-time ceiling log2, used to size counters and ports
package calc_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_SWAP   = 3'b011;
    localparam logic [2:0] OP_DUP    = 3'b100;
    localparam logic [2:0] OP_POP    = 3'b101;
    localparam logic [2:0] OP_PUSH   = 3'b110;
    localparam logic [2:0] OP_APPEND = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StMul  = 2'd2
    } state_e;

    // Smallest r with 2**r >= value (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/calc_stack.sv
// calc_stack
// Register-array LIFO with an occupancy counter. The caller guarantees that
// at most one action is asserted per cycle and that it is legal for the
// current occupancy (no push when full, no pop when empty, etc.).
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset (clears size)
//   push_i                write wdata_i above TOS, size + 1
//   pop_i                 discard TOS, size - 1
//   replace_top_i         overwrite TOS with wdata_i
//   replace_two_i         pop two, push wdata_i (size - 1)
//   swap_i                exchange TOS and NOS
//   wdata_i               write data for push / replace actions
//   tos_o, nos_o          top and next-on-stack, 0 when not present
//   size_o                number of valid entries
module calc_stack
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       replace_top_i,
    input  logic                       replace_two_i,
    input  logic                       swap_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           tos_o,
    output logic [WIDTH-1:0]           nos_o,
    output logic [clog2(DEPTH+1)-1:0]  size_o
);

    localparam int unsigned SW = clog2(DEPTH + 1);
    localparam int unsigned IW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SW-1:0]    size_q, size_d;
    logic [IW-1:0]    idx_push, idx_top, idx_nos;

    assign idx_push = IW'(size_q);
    assign idx_top  = IW'(size_q - SW'(1));
    assign idx_nos  = IW'(size_q - SW'(2));

    assign tos_o  = (size_q >= SW'(1)) ? mem_q[idx_top] : '0;
    assign nos_o  = (size_q >= SW'(2)) ? mem_q[idx_nos] : '0;
    assign size_o = size_q;

    always_comb begin
        size_d = size_q;
        if (push_i) begin
            size_d = size_q + SW'(1);
        end else if (pop_i || replace_two_i) begin
            size_d = size_q - SW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            size_q <= '0;
        end else begin
            size_q <= size_d;
        end
    end

    // Entry contents need no reset: anything at or above size_q is never read.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[idx_push] <= wdata_i;
        end else if (replace_top_i) begin
            mem_q[idx_top] <= wdata_i;
        end else if (replace_two_i) begin
            mem_q[idx_nos] <= wdata_i;
        end else if (swap_i) begin
            mem_q[idx_top] <= mem_q[idx_nos];
            mem_q[idx_nos] <= mem_q[idx_top];
        end
    end

endmodule

// File: rtl/rpn_engine.sv
// rpn_engine
// Command-driven RPN stack calculator: FSM, ALU and shift-add multiplier in
// front of a calc_stack instance.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   cmd_valid_i      command present; accepted when cmd_ready_o is also high
//   cmd_ready_o      engine idle and able to take a command
//   cmd_op_i         opcode (see calc_pkg OP_*)
//   operand_i        switch value for PUSH / APPEND
//   err_clr_i        clears the sticky error flag
//   top_o            top of stack (0 when empty)
//   size_o           number of entries
//   empty_o, full_o  occupancy flags
//   error_o          sticky fault flag
module rpn_engine
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned IN_BITS = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [2:0]                 cmd_op_i,
    input  logic [IN_BITS-1:0]         operand_i,
    input  logic                       err_clr_i,
    output logic [WIDTH-1:0]           top_o,
    output logic [clog2(DEPTH+1)-1:0]  size_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       error_o
);

    localparam int unsigned SW = clog2(DEPTH + 1);
    localparam int unsigned CW = clog2(WIDTH + 1);

    state_e               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic [IN_BITS-1:0]   operand_q, operand_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 error_q, error_d;

    logic                 st_push, st_pop, st_rtop, st_rtwo, st_swap;
    logic [WIDTH-1:0]     st_wdata;
    logic [WIDTH-1:0]     tos, nos;
    logic [SW-1:0]        size;
    logic                 is_empty, is_full, two_ok;
    logic                 fault;
    logic [WIDTH-1:0]     operand_ext;

    calc_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .push_i        (st_push),
        .pop_i         (st_pop),
        .replace_top_i (st_rtop),
        .replace_two_i (st_rtwo),
        .swap_i        (st_swap),
        .wdata_i       (st_wdata),
        .tos_o         (tos),
        .nos_o         (nos),
        .size_o        (size)
    );

    assign is_empty    = (size == '0);
    assign is_full     = (size == SW'(DEPTH));
    assign two_ok      = (size >= SW'(2));
    assign operand_ext = {{(WIDTH - IN_BITS){1'b0}}, operand_q};

    assign cmd_ready_o = (state_q == StIdle);
    assign top_o       = tos;
    assign size_o      = size;
    assign empty_o     = is_empty;
    assign full_o      = is_full;
    assign error_o     = error_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        error_d   = error_q;
        st_push   = 1'b0;
        st_pop    = 1'b0;
        st_rtop   = 1'b0;
        st_rtwo   = 1'b0;
        st_swap   = 1'b0;
        st_wdata  = '0;
        fault     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    op_d      = cmd_op_i;
                    operand_d = operand_i;
                    // Only a MUL with two operands runs the multiplier; a
                    // faulting MUL reports through EXEC like everything else.
                    if (cmd_op_i == OP_MUL && two_ok) begin
                        state_d  = StMul;
                        acc_d    = '0;
                        mcand_d  = nos;
                        mplier_d = tos;
                        cnt_d    = '0;
                    end else begin
                        state_d = StExec;
                    end
                end
            end

            StExec: begin
                state_d = StIdle;
                unique case (op_q)
                    OP_PUSH: begin
                        if (is_full) begin
                            fault = 1'b1;
                        end else begin
                            st_push  = 1'b1;
                            st_wdata = operand_ext;
                        end
                    end
                    OP_APPEND: begin
                        st_wdata = {tos[WIDTH-IN_BITS-1:0], operand_q};
                        if (is_empty) begin
                            st_push  = 1'b1;
                            st_wdata = operand_ext;
                        end else begin
                            st_rtop = 1'b1;
                        end
                    end
                    OP_POP: begin
                        if (is_empty) begin
                            fault = 1'b1;
                        end else begin
                            st_pop = 1'b1;
                        end
                    end
                    OP_DUP: begin
                        if (is_full) begin
                            fault = 1'b1;
                        end else begin
                            st_push  = 1'b1;
                            st_wdata = tos;
                        end
                    end
                    OP_SWAP: begin
                        if (!two_ok) begin
                            fault = 1'b1;
                        end else begin
                            st_swap = 1'b1;
                        end
                    end
                    OP_ADD, OP_SUB: begin
                        if (!two_ok) begin
                            fault = 1'b1;
                        end else begin
                            st_rtwo  = 1'b1;
                            st_wdata = (op_q == OP_ADD) ? (nos + tos) : (nos - tos);
                        end
                    end
                    OP_MUL: begin
                        // Reaching EXEC with MUL means the operand check failed.
                        fault = 1'b1;
                    end
                endcase
            end

            StMul: begin
                if (cnt_q == CW'(WIDTH)) begin
                    st_rtwo  = 1'b1;
                    st_wdata = acc_q;
                    state_d  = StIdle;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // A fault on the same edge as a clear must leave the flag set.
        if (err_clr_i) begin
            error_d = 1'b0;
        end
        if (fault) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            op_q      <= OP_ADD;
            operand_q <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            error_q   <= error_d;
        end
    end

endmodule
